// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage: turns a load/store from EX/MEM into a
// request/ack handshake with the data memory, stalling the pipeline until the access finishes.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALU_Result_i,
  input  logic [31:0] muxBresult_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        err_clr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        err_o,
  output logic [1:0]  state_o
);

  // Memory handshake: mem_req_o stays high with address/data/we stable until the
  // memory returns a one-cycle mem_ack_i pulse; acks outside a request are ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       access;
  logic       aligned;

  assign access  = MemRead_i | MemWrite_i;
  assign aligned = (ALU_Result_i[1:0] == 2'b00);
  assign state_o = state;

  // Stall is combinational so the pipeline freezes in the very cycle the access is seen.
  assign stall_o = !rst_i && (((state == IDLE) && access && aligned) || (state == REQ));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= 32'd0;
      mem_wdata_o   <= 32'd0;
      rdata_o       <= 32'd0;
      rdata_valid_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      rdata_valid_o <= 1'b0;
      // A clear is overridden below by an error raised in the same cycle.
      if (err_clr_i) err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (aligned) begin
              state       <= REQ;
              mem_req_o   <= 1'b1;
              mem_we_o    <= MemWrite_i;
              mem_addr_o  <= ALU_Result_i;
              mem_wdata_o <= muxBresult_i;
              wait_cnt    <= 8'd0;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            state     <= DONE;
            mem_req_o <= 1'b0;
            if (!mem_we_o) begin
              rdata_o       <= mem_rdata_i;
              rdata_valid_o <= 1'b1;
            end
          end else if (wait_cnt == LAST_CNT) begin
            state     <= DONE;
            mem_req_o <= 1'b0;
            err_o     <= 1'b1;
            if (!mem_we_o) rdata_o <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized transactions checked
// against a transaction-level model of latency, read data and the sticky error flag.
module tb_mem_access_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] alu_result, muxb_result;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err_clr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err;
  logic [1:0]  state;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] m_rdata = 32'd0;
  logic        m_err   = 1'b0;
  logic [31:0] exp_q[$];

  mem_access_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clk_i(clk), .rst_i(rst), .MemRead_i(mem_read), .MemWrite_i(mem_write),
    .ALU_Result_i(alu_result), .muxBresult_i(muxb_result), .mem_ack_i(mem_ack),
    .mem_rdata_i(mem_rdata), .err_clr_i(err_clr), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .stall_o(stall), .rdata_o(rdata),
    .rdata_valid_o(rdata_valid), .err_o(err), .state_o(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_read = 1'b0; mem_write = 1'b0; alu_result = 32'd0; muxb_result = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0; err_clr = 1'b0;
  endtask

  // One instruction through MEM. ack_at = index of the REQ cycle carrying the ack, -1 = none.
  // Starts and ends at a falling edge with the controller idle.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input int ack_at, input logic [31:0] ack_data);
    bit acked;
    bit is_write;
    int req_cycles;
    is_write = wr;
    mem_read = rd; mem_write = wr; alu_result = addr; muxb_result = data;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom; err_clr = 1'b0;
    if (!(rd || wr)) begin
      #1;
      check("noacc_stall", stall, 0);
      check("noacc_req", mem_req, 0);
      @(negedge clk);
      clear_inputs();
      return;
    end
    if (addr[1:0] != 2'b00) begin
      err_clr = 1'($urandom_range(0, 1));
      #1;
      check("mis_stall", stall, 0);
      check("mis_req", mem_req, 0);
      @(negedge clk);
      m_err = 1'b1;
      clear_inputs();
      #1;
      check("mis_err", err, m_err);
      check("mis_req_after", mem_req, 0);
      check("mis_rvalid", rdata_valid, 0);
      check("mis_stall_after", stall, 0);
      return;
    end
    #1;
    check("det_stall", stall, 1);
    check("det_req", mem_req, 0);
    check("det_rvalid", rdata_valid, 0);
    check("det_rdata", rdata, m_rdata);
    check("det_err", err, m_err);
    @(negedge clk);
    // Expected REQ residency: ack index + 1, capped by the timeout.
    acked = (ack_at >= 0) && (ack_at < T);
    req_cycles = acked ? ack_at + 1 : T;
    for (int k = 0; k < req_cycles; k++) begin
      mem_ack = (acked && k == ack_at);
      mem_rdata = mem_ack ? ack_data : $urandom;
      // The pipeline is frozen, but a changing EX/MEM bus must not disturb the latched access.
      alu_result = $urandom; muxb_result = $urandom;
      #1;
      check("req_req", mem_req, 1);
      check("req_stall", stall, 1);
      check("req_we", mem_we, is_write);
      check("req_addr", mem_addr, addr);
      check("req_wdata", mem_wdata, data);
      @(negedge clk);
    end
    if (acked) begin
      if (!is_write) m_rdata = ack_data;
    end else begin
      m_err = 1'b1;
      if (!is_write) m_rdata = 32'd0;
    end
    exp_q.push_back(m_rdata);
    clear_inputs();
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    check("done_stall", stall, 0);
    check("done_req", mem_req, 0);
    check("done_rvalid", rdata_valid, acked && !is_write);
    check("done_rdata", rdata, exp_q.pop_front());
    check("done_err", err, m_err);
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic idle_cycle(input bit clr);
    clear_inputs();
    err_clr = clr;
    mem_ack = 1'($urandom_range(0, 1));
    #1;
    check("idle_stall", stall, 0);
    check("idle_req", mem_req, 0);
    check("idle_rvalid", rdata_valid, 0);
    @(negedge clk);
    if (clr) m_err = 1'b0;
    clear_inputs();
    #1;
    check("idle_err", err, m_err);
    check("idle_rdata", rdata, m_rdata);
  endtask

  initial begin
    bit rd, wr;
    logic [31:0] addr;
    int ack_at;

    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    mem_read = 1'b1; alu_result = 32'h40;
    #1;
    check("rst_stall", stall, 0);
    @(negedge clk);
    clear_inputs();
    #1;
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rvalid", rdata_valid, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed: load with ack in the 3rd REQ cycle, store acked at once, misaligned, timeout.
    do_access(1, 0, 32'h10, 32'h0, 2, 32'hDEADBEEF);
    do_access(0, 1, 32'h20, 32'h12345678, 0, 32'hFFFF0000);
    do_access(1, 0, 32'h13, 32'h0, 0, 32'h0);
    idle_cycle(1);
    do_access(1, 0, 32'h44, 32'h0, -1, 32'h0);
    idle_cycle(1);
    do_access(1, 1, 32'h48, 32'hCAFEF00D, 1, 32'h0BADF00D);

    // Reset during the second REQ cycle aborts the access; a late ack is ignored.
    mem_read = 1'b1; alu_result = 32'h80;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    #1;
    check("rstmid_stall", stall, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    m_rdata = 32'd0; m_err = 1'b0;
    #1;
    check("rstmid_req", mem_req, 0);
    check("rstmid_addr", mem_addr, 0);
    check("rstmid_rdata", rdata, 0);
    check("rstmid_err", err, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("rstmid_late_req", mem_req, 0);
    check("rstmid_late_rdata", rdata, m_rdata);
    check("rstmid_late_rvalid", rdata_valid, 0);
    @(negedge clk);

    // Back-to-back load then store.
    do_access(1, 0, 32'h100, 32'h0, 1, 32'h11112222);
    do_access(0, 1, 32'h104, 32'h33334444, 0, 32'h0);

    // Randomized transactions.
    for (int i = 0; i < 60; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      ack_at = int'($urandom_range(0, T + 1));
      if (ack_at >= T) ack_at = -1;
      do_access(rd, wr, addr, $urandom, ack_at, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
